// File: rtl/wb_rambus_arbiter.sv
// Round-robin arbiter that funnels NCH Wishbone-style requesters onto one shared RAM bus.
// Define RAMBUS_TIMEOUT_EN to abandon a bus cycle with ch_err when the RAM never acks.
module wb_rambus_arbiter #(
    parameter int NCH     = 2,
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  active,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_we,
    input  logic [NCH*DW/8-1:0]   ch_sel,
    input  logic [NCH*AW-1:0]     ch_adr,
    input  logic [NCH*DW-1:0]     ch_wdat,
    output logic [NCH-1:0]        ch_ack,
    output logic [NCH-1:0]        ch_err,
    output logic [DW-1:0]         ch_rdat,
    output logic                  rambus_wb_clk_o,
    output logic                  rambus_wb_rst_o,
    output logic                  rambus_wb_stb_o,
    output logic                  rambus_wb_cyc_o,
    output logic                  rambus_wb_we_o,
    output logic [DW/8-1:0]       rambus_wb_sel_o,
    output logic [DW-1:0]         rambus_wb_dat_o,
    output logic [AW-1:0]         rambus_wb_adr_o,
    input  logic                  rambus_wb_ack_i,
    input  logic [DW-1:0]         rambus_wb_dat_i
);

    localparam int SW = DW / 8;
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [GW:0] NCHV = (GW+1)'(NCH);

    if (NCH < 1 || NCH > 8 || (DW % 8) != 0 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_badParams
        $error("wb_rambus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [GW-1:0]   r_ptr;
    logic [GW-1:0]   r_gnt;
    logic [GW-1:0]   w_pick;
    logic [GW:0]     w_off;
    logic [GW:0]     w_sum;
    logic [NCH-1:0]  w_rot;
    logic [NCH-1:0]  w_gntHot;
    logic            w_found;
    logic            w_timeout;
    logic            w_bus;
    logic            r_we;
    logic [SW-1:0]   r_sel;
    logic [DW-1:0]   r_dat;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_rdat;
    logic [NCH-1:0]  r_err;

`ifdef RAMBUS_TIMEOUT_EN
    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
    logic [7:0] r_tcnt;

    // Cycles spent in BUS for the current grant; restarts at 0 on every entry.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || r_state != BUS) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 8'd1;
        end
    end

    assign w_timeout = (r_tcnt == TLIM);
`else
    assign w_timeout = 1'b0;
`endif

    // Rotate requests so bit 0 is the pointer channel; the lowest set bit wins.
    always_comb begin
        w_found = |ch_req;
        w_rot   = NCH'({ch_req, ch_req} >> r_ptr);
        w_off   = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = j[GW:0];
            end
        end
        w_sum = {1'b0, r_ptr} + w_off;
        if (w_sum >= NCHV) begin
            w_sum = w_sum - NCHV;
        end
        w_pick = w_sum[GW-1:0];
    end

    always_comb begin
        w_gntHot        = '0;
        w_gntHot[r_gnt] = 1'b1;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (active && w_found) w_next = BUS;
            BUS: begin
                if (!active)               w_next = IDLE;
                else if (rambus_wb_ack_i)  w_next = DONE;
                else if (w_timeout)        w_next = IDLE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_adr   <= '0;
            r_rdat  <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= '0;
            case (r_state)
                IDLE: begin
                    if (active && w_found) begin
                        r_gnt <= w_pick;
                        r_ptr <= (w_pick == GW'(NCH - 1)) ? '0 : w_pick + 1'b1;
                        r_we  <= ch_we[w_pick];
                        r_sel <= ch_sel[w_pick*SW +: SW];
                        r_adr <= ch_adr[w_pick*AW +: AW];
                        r_dat <= ch_wdat[w_pick*DW +: DW];
                    end
                end
                BUS: begin
                    if (!active)              r_err  <= w_gntHot;
                    else if (rambus_wb_ack_i) r_rdat <= rambus_wb_dat_i;
                    else if (w_timeout)       r_err  <= w_gntHot;
                end
                default: ;
            endcase
        end
    end

    // Every bus output is forced low while the project is disabled.
    assign w_bus           = (r_state == BUS) && active;
    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_rst_o = wb_rst_i;
    assign rambus_wb_stb_o = w_bus;
    assign rambus_wb_cyc_o = w_bus;
    assign rambus_wb_we_o  = active & r_we;
    assign rambus_wb_sel_o = active ? r_sel : '0;
    assign rambus_wb_dat_o = active ? r_dat : '0;
    assign rambus_wb_adr_o = active ? r_adr : '0;

    assign ch_ack  = (r_state == DONE) ? w_gntHot : '0;
    assign ch_err  = r_err;
    assign ch_rdat = r_rdat;

endmodule

// File: doc/wb_rambus_arbiter.md
WB_RAMBUS_ARBITER -- requirements
Module: wb_rambus_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2: number of requesting channels, range 1..8.
REQ-002 SHALL have parameter AW, default 10: shared-RAM word address width.
REQ-003 SHALL have parameter DW, default 32: data width, a multiple of 8.
REQ-004 SHALL have parameter TIMEOUT, default 16: maximum cycles to wait for rambus_wb_ack_i, range 2..255.
REQ-005 SHALL have port wb_clk_i, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port wb_rst_i, input, width 1: synchronous, active-high reset.
REQ-007 SHALL have port active, input, width 1: project enable.
REQ-008 SHALL have ports ch_req / ch_we, input, width NCH: per-channel request and write enable.
REQ-009 SHALL have port ch_sel, input, width NCH*DW/8: per-channel byte selects, channel i in slice i.
REQ-010 SHALL have ports ch_adr, input, width NCH*AW, and ch_wdat, input, width NCH*DW: per-channel address and write data.
REQ-011 SHALL have ports ch_ack / ch_err, output, width NCH: one-cycle completion pulses.
REQ-012 SHALL have port ch_rdat, output, width DW: read data, shared by all channels.
REQ-013 SHALL have outputs rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_stb_o, rambus_wb_cyc_o and rambus_wb_we_o, width 1 each.
REQ-014 SHALL have outputs rambus_wb_sel_o (DW/8), rambus_wb_dat_o (DW) and rambus_wb_adr_o (AW).
REQ-015 SHALL have inputs rambus_wb_ack_i, width 1, and rambus_wb_dat_i, width DW.

Function
REQ-016 SHALL drive rambus_wb_clk_o = wb_clk_i and rambus_wb_rst_o = wb_rst_i combinationally.
REQ-017 SHALL implement FSM states IDLE, BUS and DONE.
REQ-018 SHALL move IDLE->BUS when active=1 and any ch_req=1, granting round-robin starting at the channel after the last grant; channel 0 has first priority after reset.
REQ-019 SHALL, on grant, register the granted channel's we/sel/adr/wdat and assert stb=cyc=1 on the next cycle; the request-to-stb latency is exactly 1 cycle.
REQ-020 SHALL hold all bus outputs stable in BUS until rambus_wb_ack_i=1, then latch rambus_wb_dat_i into ch_rdat, deassert stb/cyc and go to DONE.
REQ-021 SHALL pulse ch_ack[grant] for exactly the one DONE cycle, then return to IDLE; ch_rdat is held until the next completion.
REQ-022 SHALL leave the requester responsible for dropping ch_req in the cycle after ch_ack; a request still high re-enters arbitration.
REQ-023 SHALL ignore ch_req in BUS and DONE; back-to-back transactions therefore occur at most once every 3 cycles plus the ack wait.
REQ-024 SHALL, if active falls in BUS, abort: deassert stb/cyc next cycle, pulse ch_err[grant] for one cycle and go to IDLE.
REQ-025 SHALL drive rambus_wb_stb/cyc/we/sel/dat/adr to 0 whenever active=0, regardless of state.
REQ-026 SHALL ignore a rambus_wb_ack_i that arrives outside BUS.

Reset
REQ-027 SHALL, with wb_rst_i=1 at a clock edge, go to IDLE, clear stb/cyc/we/sel/dat/adr, ch_ack, ch_err and ch_rdat, and reset the round-robin pointer so channel 0 has priority.
REQ-028 SHALL, on reset mid-transaction, abandon the transaction with no ack or err pulse.

Configuration
REQ-029 SHALL, with RAMBUS_TIMEOUT_EN defined, count cycles in BUS; when TIMEOUT cycles pass without ack, drop stb/cyc, pulse ch_err[grant] and go to IDLE.
REQ-030 SHALL, without RAMBUS_TIMEOUT_EN, have no timeout counter and wait in BUS indefinitely; ch_err is then driven only by an abort on active falling.

Verification
REQ-031 SHALL cover: ch0 read at adr 0x005, RAM acks 2 cycles after stb with 0xDEADBEEF -> ch_ack[0] pulses once and ch_rdat=0xDEADBEEF.
REQ-032 SHALL cover: ch0 and ch1 request simultaneously and continuously -> grants alternate 0,1,0,1 over four transactions.
REQ-033 SHALL cover: ch1 write sel=4'b0011 dat=0x12345678 adr=0x3FF -> bus shows those values, we=1, stb held until ack.
REQ-034 SHALL cover: RAMBUS_TIMEOUT_EN defined with TIMEOUT=16 and no ack -> stb drops and ch_err pulses after 16 cycles, with no ch_ack.
REQ-035 SHALL cover: active cleared in BUS -> all bus outputs 0 and ch_err pulses; wb_rst_i in BUS -> state IDLE, no pulse.
